dreg_rr_arb: RTL and testbench
==============================

// Module: dreg_rr_arb
// PURPOSE
//  N-input round-robin arbiter that shares one registered DTI output stage between N producers.
//  - Output stage is a single-entry register; it accepts new data when empty or when dout.ready=1.
//  - Sits where several pipelines converge onto one downstream consumer (e.g. a shared bus port).
//  - dout.data is {grant index, payload}, so the consumer can demultiplex responses.
// PARAMETERS
//  N      2   number of requesters, N >= 2
//  DIN    16  payload width per requester, bits
//  IDW    $clog2(N)  grant-index width (derived, not overridable)
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst         in   1        synchronous reset, active-high
//  din_data    in   N*DIN    payload, requester i in bits [i*DIN +: DIN]
//  din_valid   in   N        requester i has data
//  din_ready   out  N        requester i transfer accepted this cycle (one-hot or zero)
//  dout        dti.producer  data width IDW+DIN = {idx[IDW-1:0], payload}; valid; ready (input)
// BEHAVIOUR
//  - Register control: reg_ready = !out_valid | dout.ready (combinational).
//  - Arbitration (combinational, only when reg_ready=1):
//    - Search requesters ptr+1, ptr+2, ... mod N.
//    - First i with din_valid[i]=1 wins.
//    - din_ready = onehot(win), else 0.
//  - Transfer: din_valid[win] & din_ready[win] in the same cycle.
//    - At the next edge: out_data <= {win, din_data[win]}, out_valid <= 1, ptr <= win.
//  - reg_ready=1 with no valid requester: out_valid <= 0 at the next edge (the output drains); ptr holds.
//  - Latency: 1 cycle from an accepted input to dout.valid.
//  - Throughput: 1 transfer/cycle while dout.ready=1.
//  - Backpressure: dout.valid=1 & dout.ready=0 -> all din_ready=0, out_data/out_valid hold.
//  - Fairness: a continuously-valid requester waits at most N-1 grants.
//  - Reset:
//    - out_valid=0 and out_data=0, so dout.valid=0 and dout.data=0.
//    - ptr=N-1, so requester 0 has first priority.
//    - din_ready=0 during the reset cycle.
//    - Reset mid-transfer drops the held word without presenting it; no partial state survives.
//  - dout.valid must not depend combinationally on din_valid; dout.valid and dout.data are register outputs only.
//  - din_valid deasserting without a transfer is tolerated; arbitration is re-evaluated every cycle.
//  - Simultaneous events:
//    - dout.ready=1 with a new winner in the same cycle: the old word leaves and the new word loads at the same edge.
//    - N=2 with both inputs valid: grants alternate 0,1,0,1.
// CONFIGURATION
//  DREG_RR_ARB_PKT_LOCK_EN
//  - Defined: packet lock.
//    - payload bit DIN-1 is EOT.
//    - FSM states: IDLE, LOCKED.
//    - IDLE -> LOCKED on a transfer with EOT=0; the lock is held on win.
//    - In LOCKED only lock_id is eligible; other requesters see din_ready=0 even if it idles.
//    - LOCKED -> IDLE on a lock_id transfer with EOT=1.
//    - ptr updates only on the EOT transfer.
//    - Reset -> IDLE.
//  - Undefined: no FSM; arbitration per word, as above; bit DIN-1 is ordinary payload.
// TESTING
//  1 Reset.
//    - rst=1 for 2 cycles, with all din_valid=1.
//    - Required: dout.valid=0, din_ready=0.
//    - First grant after reset goes to idx 0.
//  2 N=4, all valid, dout.ready=1, payloads 0xA0..0xA3.
//    - Required: dout sequence {0,A0},{1,A1},{2,A2},{3,A3},{0,A0}; one output per cycle.
//  3 Backpressure.
//    - Hold dout.ready=0 for 5 cycles with word {2,0x55} held.
//    - Required: dout stable, din_ready=0.
//    - On release, the next winner is idx 3.
//  4 Sparse requests.
//    - Only din_valid[1] is set, for one cycle.
//    - Required: dout={1,x} for exactly one cycle.
//    - Then dout.valid=0 with ready=1.
//  5 Reset mid-stream.
//    - Assert rst while dout.valid=1 and dout.ready=0.
//    - Required: next cycle dout.valid=0, ptr reset, idx 0 granted first.
//  6 LOCK_EN.
//    - idx1 sends 3 words (EOT on the third) with idx0 continuously valid.
//    - Required: idx1's words are contiguous on dout and idx0 gets no grant until after EOT.
//    - Without the macro, grants alternate.

Source files
------------

// File: rtl/dreg_rr_arb_if.sv
// dti: valid/ready data-transfer interface, producer drives data/valid, consumer drives ready
interface dti #(
   parameter int W = 8
) ();
   logic [W-1:0] data;
   logic         valid;
   logic         ready;
   modport producer(output data, output valid, input ready);
   modport consumer(input data, input valid, output ready);
endinterface

// File: rtl/dreg_rr_arb.sv
// dreg_rr_arb: N-input round-robin arbiter feeding one registered dti output stage
// Optional packet lock (payload MSB = EOT) enabled by defining DREG_RR_ARB_PKT_LOCK_EN
module dreg_rr_arb #(
   parameter int N = 2,
   parameter int DIN = 16,
   localparam int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*DIN-1:0] din_data,
   input  logic [N-1:0]     din_valid,
   output logic [N-1:0]     din_ready,
   dti.producer             dout
);
   logic [IDW+DIN-1:0] out_data;
   logic               out_valid;
   logic               reg_ready;
   logic               found;
   logic               grant;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     win;
   logic [N-1:0]       elig;
   logic [DIN-1:0]     win_payload;
`ifdef DREG_RR_ARB_PKT_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t         state;
   logic [IDW-1:0] lock_id;
   // while a packet is open only its owner may compete, even when it idles
   assign elig = (state == LOCKED) ? din_valid & (N'(1) << lock_id) : din_valid;
`else
   assign elig = din_valid;
`endif
   assign reg_ready = !out_valid || dout.ready;
   always_comb begin
      found = 1'b0;
      win = ptr;
      for (int k = 1; k <= N; k++)
         if (!found && elig[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            win = IDW'((int'(ptr) + k) % N);
         end
   end
   assign grant = found && reg_ready && !rst;
   assign din_ready = grant ? N'(1) << win : '0;
   assign win_payload = din_data[int'(win)*DIN +: DIN];
   assign dout.valid = out_valid;
   assign dout.data = out_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data <= '0;
         ptr <= IDW'(N - 1);
`ifdef DREG_RR_ARB_PKT_LOCK_EN
         state <= IDLE;
         lock_id <= '0;
`endif
      end else if (reg_ready) begin
         out_valid <= grant;
         if (grant) out_data <= {win, win_payload};
`ifdef DREG_RR_ARB_PKT_LOCK_EN
         if (grant && win_payload[DIN-1]) begin
            ptr <= win;
            state <= IDLE;
         end else if (grant && state == IDLE) begin
            state <= LOCKED;
            lock_id <= win;
         end
`else
         if (grant) ptr <= win;
`endif
      end
   end
endmodule

// File: tb/tb_dreg_rr_arb.sv
// tb_dreg_rr_arb: directed self-checking bench for dreg_rr_arb with N=4, DIN=16
module tb_dreg_rr_arb;
   localparam int N = 4;
   localparam int DIN = 16;
   localparam int IDW = 2;
   localparam int W = IDW + DIN;
   logic             clk = 1'b0;
   logic             rst;
   logic [N*DIN-1:0] din_data;
   logic [N-1:0]     din_valid;
   logic [N-1:0]     din_ready;
   int               errors = 0;
   int               checks = 0;
   dti #(.W(W)) dout_if ();
   dreg_rr_arb #(.N(N), .DIN(DIN)) dut (
      .clk(clk),
      .rst(rst),
      .din_data(din_data),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .dout(dout_if)
   );
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      din_valid = '0;
      dout_if.ready = 1'b1;
      for (int i = 0; i < N; i++) din_data[i*DIN +: DIN] = 16'h00A0 + 16'(i);
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      din_valid = '1;
      dout_if.ready = 1'b1;
      for (int i = 0; i < N; i++) din_data[i*DIN +: DIN] = 16'h00A0 + 16'(i);
      tick;
      tick;
      checks++;
      if (dout_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", dout_if.valid);
      end
      checks++;
      if (dout_if.data !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", dout_if.data);
      end
      checks++;
      if (din_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_din_ready: got %b expected 0000", din_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (din_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant: got %b expected 0001", din_ready);
      end
      tick;
      checks++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== {2'd0, 16'h00A0}) begin
         errors++;
         $display("FAIL reset_first_word: got %b/%h expected 1/%h", dout_if.valid, dout_if.data, {2'd0, 16'h00A0});
      end
   endtask

   task automatic test_round_robin;
      do_reset;
      din_valid = '1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (din_ready !== 4'(1 << (k % 4))) begin
            errors++;
            $display("FAIL rr_ready%0d: got %b expected %b", k, din_ready, 4'(1 << (k % 4)));
         end
         tick;
         checks++;
         if (dout_if.valid !== 1'b1 || dout_if.data !== {2'(k % 4), 16'h00A0 + 16'(k % 4)}) begin
            errors++;
            $display("FAIL rr_word%0d: got %b/%h expected 1/%h", k, dout_if.valid, dout_if.data, {2'(k % 4), 16'h00A0 + 16'(k % 4)});
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset;
      din_data[2*DIN +: DIN] = 16'h0055;
      din_valid = 4'b0100;
      tick;
      dout_if.ready = 1'b0;
      din_valid = '1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (din_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready%0d: got %b expected 0000", k, din_ready);
         end
         checks++;
         if (dout_if.valid !== 1'b1 || dout_if.data !== {2'd2, 16'h0055}) begin
            errors++;
            $display("FAIL bp_hold%0d: got %b/%h expected 1/%h", k, dout_if.valid, dout_if.data, {2'd2, 16'h0055});
         end
         tick;
      end
      dout_if.ready = 1'b1;
      #1;
      checks++;
      if (din_ready !== 4'b1000) begin
         errors++;
         $display("FAIL bp_release_grant: got %b expected 1000", din_ready);
      end
      tick;
      checks++;
      if (dout_if.data !== {2'd3, 16'h00A3}) begin
         errors++;
         $display("FAIL bp_release_word: got %h expected %h", dout_if.data, {2'd3, 16'h00A3});
      end
   endtask

   task automatic test_sparse;
      do_reset;
      din_valid = 4'b0010;
      tick;
      checks++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== {2'd1, 16'h00A1}) begin
         errors++;
         $display("FAIL sparse_word: got %b/%h expected 1/%h", dout_if.valid, dout_if.data, {2'd1, 16'h00A1});
      end
      din_valid = '0;
      #1;
      checks++;
      if (din_ready !== 4'b0000) begin
         errors++;
         $display("FAIL sparse_idle_ready: got %b expected 0000", din_ready);
      end
      for (int k = 0; k < 2; k++) begin
         tick;
         checks++;
         if (dout_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL sparse_drain%0d: got %b expected 0", k, dout_if.valid);
         end
      end
   endtask

   task automatic test_reset_mid_stream;
      do_reset;
      din_valid = 4'b0100;
      tick;
      dout_if.ready = 1'b0;
      rst = 1'b1;
      tick;
      checks++;
      if (dout_if.valid !== 1'b0 || dout_if.data !== '0) begin
         errors++;
         $display("FAIL midrst_drop: got %b/%h expected 0/0", dout_if.valid, dout_if.data);
      end
      rst = 1'b0;
      din_valid = '1;
      dout_if.ready = 1'b1;
      #1;
      checks++;
      if (din_ready !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_grant: got %b expected 0001", din_ready);
      end
      tick;
      checks++;
      if (dout_if.data !== {2'd0, 16'h00A0}) begin
         errors++;
         $display("FAIL midrst_word: got %h expected %h", dout_if.data, {2'd0, 16'h00A0});
      end
   endtask

   task automatic test_pkt_lock;
      logic [15:0] words [0:2];
      logic [W-1:0] exp6 [0:5];
      int w1;
      logic acc;
      words[0] = 16'h0011;
      words[1] = 16'h0012;
      words[2] = 16'h8013;
`ifdef DREG_RR_ARB_PKT_LOCK_EN
      exp6[0] = {2'd0, 16'h80A0};
      exp6[1] = {2'd1, 16'h0011};
      exp6[2] = {2'd1, 16'h0012};
      exp6[3] = {2'd1, 16'h8013};
      exp6[4] = {2'd0, 16'h80A0};
      exp6[5] = {2'd0, 16'h80A0};
`else
      exp6[0] = {2'd0, 16'h80A0};
      exp6[1] = {2'd1, 16'h0011};
      exp6[2] = {2'd0, 16'h80A0};
      exp6[3] = {2'd1, 16'h0012};
      exp6[4] = {2'd0, 16'h80A0};
      exp6[5] = {2'd1, 16'h8013};
`endif
      do_reset;
      din_data[0 +: DIN] = 16'h80A0;
      w1 = 0;
      for (int c = 0; c < 6; c++) begin
         if (w1 < 3) din_data[DIN +: DIN] = words[w1];
         din_valid = {2'b00, w1 < 3, 1'b1};
         #1;
         acc = din_ready[1];
         tick;
         checks++;
         if (dout_if.valid !== 1'b1 || dout_if.data !== exp6[c]) begin
            errors++;
            $display("FAIL lock_word%0d: got %b/%h expected 1/%h", c, dout_if.valid, dout_if.data, exp6[c]);
         end
         if (acc) w1++;
      end
   endtask

   initial begin
      rst = 1'b1;
      din_valid = '0;
      din_data = '0;
      dout_if.ready = 1'b1;
      test_reset;
      test_round_robin;
      test_backpressure;
      test_sparse;
      test_reset_mid_stream;
      test_pkt_lock;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
